// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and state type for the PS/2 receiver
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam int DEF_FILTER_LEN = 8;
  localparam int DEF_TIMEOUT_CYC = 20000;
  typedef enum logic [1:0] {IDLE, DATOS, PARIDAD, PARADA} estado_t;
endpackage

// File: rtl/filtro_ps2.sv
// filtro_ps2: synchronises the PS/2 lines, debounces the clock and flags its falling edges
module filtro_ps2 import ps2_pkg::*; #(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic datos_sinc,
  output logic caida
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] r_c_s, r_d_s;
  logic r_filt, r_filt_q;
  logic [CW-1:0] r_cnt;
  logic w_lleno;
  assign w_lleno = r_cnt == CW'(FILTER_LEN - 1);
  assign datos_sinc = r_d_s[1];
  assign caida = r_filt_q & ~r_filt;
  // Lines idle high, so synchronisers and filter come out of reset high to avoid a false edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_c_s <= 2'b11;
      r_d_s <= 2'b11;
      r_filt <= 1'b1;
      r_filt_q <= 1'b1;
      r_cnt <= '0;
    end else begin
      r_c_s <= {r_c_s[0], ps2_clk};
      r_d_s <= {r_d_s[0], ps2_data};
      r_filt_q <= r_filt;
      r_cnt <= (r_c_s[1] != r_filt && !w_lleno) ? r_cnt + CW'(1) : '0;
      r_filt <= (r_c_s[1] != r_filt && w_lleno) ? r_c_s[1] : r_filt;
    end
endmodule

// File: rtl/receptor_ps2.sv
// receptor_ps2: PS/2 keyboard frame receiver with break/extended prefix stripping
module receptor_ps2 import ps2_pkg::*; #(
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] Letra,
  output logic       TecladoReady,
  output logic       TeclaLiberada,
  output logic       Extendida,
  output logic       ErrorTrama
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic w_caida, w_dat, w_tout, w_ok;
  estado_t r_estado;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic r_par, r_brk, r_ext;
  logic [TW-1:0] r_tout;
  filtro_ps2 #(.FILTER_LEN(FILTER_LEN)) u_filtro (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .datos_sinc(w_dat), .caida(w_caida)
  );
  assign w_tout = (r_estado != IDLE) && (r_tout == TW'(TIMEOUT_CYC));
  assign w_ok = (^{r_shift, r_par}) && w_dat;
  // Timeout is tested first so an expiring counter overrides a coincident edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_estado <= IDLE;
      r_shift <= '0;
      r_bit <= '0;
      r_par <= 1'b0;
      r_brk <= 1'b0;
      r_ext <= 1'b0;
      r_tout <= '0;
      Letra <= '0;
      TecladoReady <= 1'b0;
      TeclaLiberada <= 1'b0;
      Extendida <= 1'b0;
      ErrorTrama <= 1'b0;
    end else begin
      TecladoReady <= 1'b0;
      ErrorTrama <= 1'b0;
      r_tout <= (r_estado == IDLE || w_caida) ? '0 : r_tout + TW'(1);
      if (w_tout) begin
        ErrorTrama <= 1'b1;
        r_brk <= 1'b0;
        r_ext <= 1'b0;
        r_estado <= IDLE;
        r_tout <= '0;
      end else if (w_caida)
        case (r_estado)
          IDLE: if (!w_dat) begin
            r_estado <= DATOS;
            r_bit <= '0;
          end
          DATOS: begin
            r_shift <= {w_dat, r_shift[7:1]};
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_estado <= PARIDAD;
          end
          PARIDAD: begin
            r_par <= w_dat;
            r_estado <= PARADA;
          end
          default: begin
            r_estado <= IDLE;
            if (!w_ok) begin
              ErrorTrama <= 1'b1;
              r_brk <= 1'b0;
              r_ext <= 1'b0;
            end else if (r_shift == PS2_BREAK) r_brk <= 1'b1;
            else if (r_shift == PS2_EXT) r_ext <= 1'b1;
            else begin
              Letra <= r_shift;
              TeclaLiberada <= r_brk;
              Extendida <= r_ext;
              TecladoReady <= 1'b1;
              r_brk <= 1'b0;
              r_ext <= 1'b0;
            end
          end
        endcase
    end
endmodule
